// File: rtl/bus_dev_fifo.sv
// Show-ahead packet FIFO between a bus device and the bus arbiter.
// The head packet is always on D_pop; pndng doubles as the device's bus request.
module bus_dev_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [pckg_sz-1:0]           D_push,
    input  logic                         pop,
    output logic [pckg_sz-1:0]           D_pop,
    output logic                         pndng,
    output logic                         full,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
    localparam logic [AW-1:0] LAST_PTR = AW'(depth - 1);

    logic [pckg_sz-1:0] mem [depth];
    logic [AW-1:0]      wp;
    logic [AW-1:0]      rp;
    logic               push_acc;
    logic               pop_acc;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    // Status decodes of the registered count, so they clear with reset at once
    assign pndng = (count != '0);
    assign full  = (count == FULL_CNT);

    // A full FIFO may still take a packet when the head leaves on the same edge
    assign pop_acc  = pop && pndng;
    assign push_acc = push && (!full || pop_acc);

    assign D_pop = pndng ? mem[rp] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc)
                wp <= ptr_next(wp);
            if (pop_acc)
                rp <= ptr_next(rp);
            unique case ({push_acc, pop_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !push_acc)
                overflow <= 1'b1;
            if (pop && !pndng)
                underflow <= 1'b1;
        end
    end

    // Packet storage carries no reset; stale entries are masked by pndng
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wp] <= D_push;
    end

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Scoreboard bench for bus_dev_fifo: stimulus enqueues expected packets,
// a negedge monitor compares D_pop against the queue on every accepted pop.
module tb_bus_dev_fifo;

    logic        clk;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        pop;
    logic [15:0] D_pop;
    logic        pndng;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    bus_dev_fifo #(.pckg_sz(16), .depth(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .D_push    (D_push),
        .pop       (pop),
        .D_pop     (D_pop),
        .pndng     (pndng),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the arbiter takes the head whenever pop meets pndng
    always @(negedge clk) begin
        if (!reset && pop && pndng) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_data: got %0h expected nothing (scoreboard empty)", D_pop);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (D_pop !== e) begin
                    failures++;
                    $display("FAIL pop_data: got %0h expected %0h", D_pop, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step(input logic p, input logic [15:0] d, input logic q);
        push   = p;
        D_push = d;
        pop    = q;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push  = 1'b0;
        pop   = 1'b0;
        #1 reset = 1'b1;
        exp_q.delete();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] nxt;

    initial begin
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        D_push = '0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_pndng", pndng, 0);
        chk("rst_full", full, 0);
        chk("rst_dpop", D_pop, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three pushes, then drain
        exp_q.push_back(16'h1111); step(1, 16'h1111, 0);
        chk("lat_dpop", D_pop, 16'h1111);
        chk("lat_pndng", pndng, 1);
        exp_q.push_back(16'h2222); step(1, 16'h2222, 0);
        exp_q.push_back(16'h3333); step(1, 16'h3333, 0);
        chk("b3_count", count, 3);
        chk("b3_pndng", pndng, 1);
        chk("b3_dpop", D_pop, 16'h1111);
        step(0, 0, 1);
        chk("b3_next1", D_pop, 16'h2222);
        step(0, 0, 1);
        chk("b3_next2", D_pop, 16'h3333);
        step(0, 0, 1);
        chk("b3_empty_dpop", D_pop, 0);
        chk("b3_empty_pndng", pndng, 0);

        // Fill, overflow push, drain
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(16'(i));
            step(1, 16'(i), 0);
        end
        step(1, 16'h0009, 0);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_dpop", D_pop, 16'h0001);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        chk("ovf_drained", pndng, 0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_udf", underflow, 0);

        // Push and pop together while full
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(16'(i));
            step(1, 16'(i), 0);
        end
        exp_q.push_back(16'h00AA);
        step(1, 16'h00AA, 1);
        chk("fpp_count", count, 8);
        chk("fpp_full", full, 1);
        chk("fpp_dpop", D_pop, 16'h0002);
        chk("fpp_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        chk("fpp_drained", pndng, 0);

        // Push and pop together while empty
        do_reset();
        exp_q.push_back(16'h0BEE);
        step(1, 16'h0BEE, 1);
        chk("epp_count", count, 1);
        chk("epp_dpop", D_pop, 16'h0BEE);
        chk("epp_udf", underflow, 1);
        chk("epp_ovf", overflow, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("udf_sticky", underflow, 1);
        chk("udf_count", count, 0);
        chk("udf_dpop", D_pop, 0);

        // Streaming across pointer wrap, occupancy held at 3..5
        do_reset();
        nxt = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(nxt); step(1, nxt, 0); nxt++;
        end
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0:       begin exp_q.push_back(nxt); step(1, nxt, 0); nxt++; end
                2:       step(0, 0, 1);
                default: begin exp_q.push_back(nxt); step(1, nxt, 1); nxt++; end
            endcase
            chk("wrap_range", (count >= 3 && count <= 5), 1);
        end
        chk("wrap_count", count, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("wrap_pndng", pndng, 0);
        chk("wrap_ovf", overflow, 0);
        chk("wrap_udf", underflow, 0);

        // Asynchronous reset mid-cycle with packets stored
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(16'h0A00 + 16'(i));
            step(1, 16'h0A00 + 16'(i), 0);
        end
        chk("ar_pre_count", count, 5);
        push = 1'b0;
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("ar_count", count, 0);
        chk("ar_pndng", pndng, 0);
        chk("ar_dpop", D_pop, 0);
        chk("ar_full", full, 0);
        chk("ar_ovf", overflow, 0);
        chk("ar_udf", underflow, 0);
        push = 1'b1; D_push = 16'hDEAD; pop = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_ignored_count", count, 0);
        chk("ar_ignored_udf", underflow, 0);
        push = 1'b0; pop = 1'b0;
        #2 reset = 1'b0;
        exp_q.push_back(16'h5A5A);
        step(1, 16'h5A5A, 0);
        chk("ar_first_dpop", D_pop, 16'h5A5A);
        chk("ar_first_pndng", pndng, 1);
        chk("ar_first_count", count, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("ar_end_pndng", pndng, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_dev_fifo.md
BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 Parameter pckg_sz, default 16, packet width in bits; matches bus pckg_sz.
REQ-002 Parameter depth, default 8, packet entries; power of two, >= 2.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 push  input  1  producer-side write strobe, sampled at rising clk.
REQ-007 D_push  input  pckg_sz  packet written when push=1.
REQ-008 pop  input  1  bus-side read strobe from the arbiter, sampled at rising clk.
REQ-009 D_pop  output  pckg_sz  head packet presented to the bus (show-ahead).
REQ-010 pndng  output  1  FIFO non-empty; the bus request for this device.
REQ-011 full  output  1  count == depth.
REQ-012 count  output  $clog2(depth+1)  entries currently stored.
REQ-013 overflow  output  1  sticky: a push was dropped.
REQ-014 underflow  output  1  sticky: a pop arrived while empty.

Function
REQ-015 Storage SHALL be a circular buffer with write pointer wp and read pointer rp, each log2(depth) bits, wrapping from depth-1 to 0.
REQ-016 Push accepted when push=1 and (full=0 or pop=1 with pndng=1); mem[wp] <= D_push, wp advances.
REQ-017 Pop accepted when pop=1 and pndng=1; rp advances.
REQ-018 count update per edge: +1 push only, -1 pop only, unchanged for both or neither; never exceeds depth, never below 0.
REQ-019 Latency: packet pushed at edge N SHALL appear on D_pop with pndng=1 after edge N when FIFO was empty (1-cycle write-to-read).
REQ-020 D_pop SHALL equal mem[rp] when pndng=1 and all-zeros when pndng=0.
REQ-021 After accepted pop at edge N, D_pop SHALL show the next entry after edge N (no bubble).
REQ-022 pndng, full SHALL be registered-equivalent decodes of count (pndng = count!=0, full = count==depth).
REQ-023 Push while full with pop=0: packet dropped, state unchanged, overflow <= 1.
REQ-024 Push and pop at same edge while full: both accepted, count stays depth, overflow unchanged.
REQ-025 Push and pop at same edge while empty: push accepted, pop ignored, underflow <= 1, count becomes 1.
REQ-026 Pop while empty without push: ignored, underflow <= 1.
REQ-027 overflow and underflow SHALL stay set until reset.
REQ-028 Packet order SHALL be strictly FIFO across pointer wrap-around.

Reset
REQ-029 reset=1 SHALL immediately (no clk needed) force wp=0, rp=0, count=0, pndng=0, full=0, D_pop=0, overflow=0, underflow=0.
REQ-030 Memory contents need not be cleared; they SHALL be unobservable on D_pop after reset.
REQ-031 Reset mid-operation SHALL discard all stored packets; push/pop sampled while reset=1 are ignored.
REQ-032 First push after reset deasserts SHALL appear on D_pop one edge later, per REQ-019.

Verification
REQ-033 Push 0x1111, 0x2222, 0x3333 on consecutive edges, no pop -> count=3, pndng=1, D_pop=0x1111; three pops -> D_pop 0x2222, 0x3333, then 0x0000 with pndng=0.
REQ-034 Fill 8 entries 0x0001..0x0008, push 0x0009 -> full=1, count=8, overflow=1; drain -> 0x0001..0x0008 in order, 0x0009 never seen.
REQ-035 Full FIFO, push 0x00AA with pop same edge -> count=8, D_pop advances by one, 0x00AA emerges last, overflow=0.
REQ-036 Empty FIFO, push 0x0BEE with pop same edge -> count=1, D_pop=0x0BEE, underflow=1.
REQ-037 Push/pop 20 packets keeping count 3..5 -> pointer wrap exercised, output order equals input order, no flags set.
REQ-038 Assert reset asynchronously mid-clock with count=5 -> pndng=0, count=0, D_pop=0, flags 0 before next edge; push 0x5A5A after release -> D_pop=0x5A5A next edge.
